eprobe_led_monitor: RTL and testbench

EPROBE_LED_MONITOR -- requirements
Module: eprobe_led_monitor

---
 rtl/eprobe_pkg.sv | 21 ++
 rtl/eprobe_shadow_ram.sv | 24 ++
 rtl/eprobe_led_monitor.sv | 138 +++++++++++++
 tb/tb_eprobe_led_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/eprobe_pkg.sv
// Shared constants, state encoding and entry type for the eprobe LED monitor.
package eprobe_pkg;
    localparam int NUM_LEDS = 512;
    localparam int IDX_W    = 9;
    localparam int VLED_W   = 3;
    localparam int ENTRY_W  = 4;
    localparam int ACT_W    = 10;
    localparam int UPD_W    = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Entry layout is {en, vled}; en is the MSB.
    function automatic entry_t pack_entry(input logic en, input logic [VLED_W-1:0] vled);
        return {en, vled};
    endfunction
endpackage

// File: rtl/eprobe_shadow_ram.sv
// 512x4 shadow table: one synchronous write port, two combinational read ports
// (host readback and old-value lookup for the enable-count bookkeeping).
module eprobe_shadow_ram
    import eprobe_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  entry_t           wdata,
    input  logic [IDX_W-1:0] rd_addr,
    output entry_t           rd_q,
    input  logic [IDX_W-1:0] old_addr,
    output entry_t           old_q
);
    // No reset on the array: the CLEAR sweep zeroes it.
    entry_t mem [NUM_LEDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd_q  = mem[rd_addr];
    assign old_q = mem[old_addr];
endmodule

// File: rtl/eprobe_led_monitor.sv
// Shadows the LED controller's per-LED {en, vled} state for host readback.
// Optional statistics counters are built only when EPROBE_MON_STATS_EN is defined.
module eprobe_led_monitor
    import eprobe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:1]        pix,
    input  logic [6:1]        addr,
    input  logic              probe,
    input  logic [3:1]        vled,
    input  logic              en_led,
    input  logic              load,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output entry_t            rd_data,
    output logic              busy,
    output logic              overrun,
    output logic [ACT_W-1:0]  active_count,
    output logic [UPD_W-1:0]  update_count
);
    state_t           state, state_nxt;
    logic [IDX_W-1:0] sweep, sweep_nxt;
    logic             clearing;
    logic             load_q;
    logic             load_edge;
    logic             accept;
    logic [IDX_W-1:0] idx;
    entry_t           new_entry;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    entry_t           ram_wdata;
    entry_t           ram_rd;
    entry_t           old_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        clearing  = 1'b0;
        case (state)
            ST_CLEAR: begin
                clearing  = 1'b1;
                sweep_nxt = sweep + 1'b1;
                if (sweep == IDX_W'(NUM_LEDS - 1)) state_nxt = ST_RUN;
            end
            ST_RUN:  ;
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy = clearing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_q <= 1'b0;
        else     load_q <= load;
    end

    assign load_edge = load & ~load_q;
    assign accept    = load_edge & ~clearing;
    assign idx       = {probe, addr, pix};
    assign new_entry = pack_entry(en_led, vled);

    // The sweep owns the write port while clearing; loads are refused then.
    assign ram_we    = clearing | accept;
    assign ram_waddr = clearing ? sweep : idx;
    assign ram_wdata = clearing ? entry_t'('0) : new_entry;

    eprobe_shadow_ram u_ram (
        .clk      (clk),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .rd_addr  (rd_idx),
        .rd_q     (ram_rd),
        .old_addr (idx),
        .old_q    (old_entry)
    );

    // Readback is write-first: a same-cycle load to the same index forwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (clearing)                     rd_data <= '0;
                else if (accept && idx == rd_idx) rd_data <= new_entry;
                else                              rd_data <= ram_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        overrun <= 1'b0;
        else if (load_edge && clearing) overrun <= 1'b1;
    end

`ifdef EPROBE_MON_STATS_EN
    logic [ACT_W-1:0] act_q;
    logic [UPD_W-1:0] upd_q;
    logic             old_en;

    assign old_en = old_entry[ENTRY_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= '0;
            upd_q <= '0;
        end else if (accept) begin
            upd_q <= upd_q + 1'b1;
            if (en_led && !old_en && act_q != ACT_W'(NUM_LEDS))
                act_q <= act_q + 1'b1;
            else if (!en_led && old_en && act_q != '0)
                act_q <= act_q - 1'b1;
        end
    end

    assign active_count = act_q;
    assign update_count = upd_q;
`else
    logic unused_old;
    assign unused_old   = ^old_entry;
    assign active_count = '0;
    assign update_count = '0;
`endif
endmodule

// File: tb/tb_eprobe_led_monitor.sv
// Directed bench: stimulus pushes expected readback into a queue, a negedge
// monitor pops and compares on rd_valid; status outputs are checked inline.
module tb_eprobe_led_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:1] pix;
    logic [6:1] addr;
    logic       probe;
    logic [3:1] vled;
    logic       en_led;
    logic       load;
    logic       rd_req;
    logic [8:0] rd_idx;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       busy;
    logic       overrun;
    logic [9:0] active_count;
    logic [15:0] update_count;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

`ifdef EPROBE_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    eprobe_led_monitor dut (
        .clk(clk), .rst(rst), .pix(pix), .addr(addr), .probe(probe),
        .vled(vled), .en_led(en_led), .load(load), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .overrun(overrun), .active_count(active_count),
        .update_count(update_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no response", rd_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_led(input logic p, input logic [5:0] a, input logic [1:0] px,
                           input logic [2:0] v, input logic e);
        probe = p; addr = a; pix = px; vled = v; en_led = e;
    endtask

    task automatic do_load(input logic p, input logic [5:0] a, input logic [1:0] px,
                           input logic [2:0] v, input logic e, input int hold);
        set_led(p, a, px, v, e);
        load = 1'b1;
        repeat (hold) tick();
        load = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [8:0] i, input logic [3:0] exp);
        exp_q.push_back(exp);
        rd_req = 1'b1;
        rd_idx = i;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic check_stats(input string name, input int act_exp, input int upd_exp);
        check({name, "_active"}, 32'(active_count), STATS ? 32'(act_exp) : 32'd0);
        check({name, "_update"}, 32'(update_count), STATS ? 32'(upd_exp) : 32'd0);
    endtask

    task automatic wait_clear(output int busy_cycles);
        busy_cycles = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (n == 50)  begin exp_q.push_back(4'h0); rd_req = 1'b1; rd_idx = 9'd300; end
            if (n == 51)  rd_req = 1'b0;
            if (n == 100) begin set_led(1'b0, 6'd1, 2'd3, 3'd7, 1'b1); load = 1'b1; end
            if (n == 101) load = 1'b0;
            if (!busy) break;
            busy_cycles++;
        end
    endtask

    initial begin
        int bc;
        rst = 1'b1; load = 1'b0; rd_req = 1'b0; rd_idx = '0;
        set_led(1'b0, 6'd0, 2'd0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check_stats("reset", 0, 0);

        // Clear sweep with a read at n=50 and a refused load at n=100 (idx 7).
        @(posedge clk); #1 rst = 1'b0;
        wait_clear(bc);
        check("busy_cycles", 32'(bc), 32'd512);
        check("overrun_set", 32'(overrun), 32'd1);
        check_stats("after_clear", 0, 0);
        tick();
        do_read(9'd7, 4'h0);
        do_read(9'd300, 4'h0);

        do_load(1'b1, 6'h2A, 2'b11, 3'b101, 1'b1, 1);
        do_read(9'h1AB, 4'b1101);
        check_stats("pulse", 1, 1);

        do_load(1'b1, 6'h2A, 2'b11, 3'b101, 1'b1, 10);
        check_stats("held", 1, 2);

        do_load(1'b1, 6'h2A, 2'b11, 3'b101, 1'b0, 1);
        do_read(9'h1AB, 4'b0101);
        check_stats("en_off", 0, 3);

        do_load(1'b1, 6'h2A, 2'b11, 3'b010, 1'b1, 1);
        do_load(1'b1, 6'h2A, 2'b11, 3'b010, 1'b1, 1);
        do_read(9'h1AB, 4'b1010);
        check_stats("en_twice", 1, 5);

        // Same-cycle write and read of idx 5 must forward the new value.
        set_led(1'b0, 6'd1, 2'd1, 3'b110, 1'b1);
        load = 1'b1; rd_req = 1'b1; rd_idx = 9'd5;
        exp_q.push_back(4'b1110);
        tick();
        load = 1'b0; rd_req = 1'b0;
        tick();
        check_stats("same_cycle", 2, 6);
        do_read(9'd5, 4'b1110);
        tick(); tick();
        check("rd_valid_idle", 32'(rd_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'hE);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a load; the table is swept again.
        set_led(1'b1, 6'h2A, 2'b11, 3'b111, 1'b1);
        load = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rerst_busy", 32'(busy), 32'd1);
        check("rerst_overrun", 32'(overrun), 32'd0);
        check("rerst_rd_valid", 32'(rd_valid), 32'd0);
        check_stats("rerst", 0, 0);
        load = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        wait_clear(bc);
        check("rerst_busy_cycles", 32'(bc), 32'd512);
        tick();
        do_read(9'h1AB, 4'h0);
        do_read(9'd5, 4'h0);
        check_stats("rerst_done", 0, 0);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
